// File: rtl/rsfq_xnor_driver_if.sv
// Operand/result handshake and SFQ pulse lines between the XNOR-cell driver and its environment.
// The master side supplies operands, the cell return line and result acceptance.
interface rsfq_xnor_driver_if;
  logic in_valid;
  logic in_ready;
  logic in_a;
  logic in_b;
  logic sfq_a;
  logic sfq_b;
  logic sfq_clk;
  logic sfq_q;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_mismatch;
  logic err_spurious;

  modport slave (
    input  in_valid, in_a, in_b, sfq_q, out_ready,
    output in_ready, sfq_a, sfq_b, sfq_clk, out_valid, out_bit, out_mismatch, err_spurious
  );

  modport master (
    output in_valid, in_a, in_b, sfq_q, out_ready,
    input  in_ready, sfq_a, sfq_b, sfq_clk, out_valid, out_bit, out_mismatch, err_spurious
  );
endinterface

// File: rtl/rsfq_xnor_driver.sv
// Drives one operand pair into an RSFQ XNOR cell as toggle-encoded pulses, clocks the cell,
// counts q pulses inside the response window and reports the result against a XNOR b.
module rsfq_xnor_driver #(
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned RESP_WINDOW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rsfq_xnor_driver_if.slave    bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PULSE_A   = 3'd1;
  localparam logic [2:0] S_GAP_A     = 3'd2;
  localparam logic [2:0] S_PULSE_B   = 3'd3;
  localparam logic [2:0] S_GAP_B     = 3'd4;
  localparam logic [2:0] S_PULSE_CLK = 3'd5;
  localparam logic [2:0] S_WAIT_Q    = 3'd6;
  localparam logic [2:0] S_RESULT    = 3'd7;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] WIN_LAST = 8'(RESP_WINDOW - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] cnt_q, cnt_d;
  logic       a_q, b_q;
  logic       sfq_a_q, sfq_b_q, sfq_clk_q;
  logic       q_prev_q, det_q;
  logic       out_valid_q, out_bit_q, out_mismatch_q, err_q;
  logic       transfer, enter_pb, enter_clk, finish_win;

  assign transfer   = (state_q == S_IDLE) && bus.in_valid;
  assign enter_pb   = (state_q == S_GAP_A) && (state_d == S_PULSE_B);
  assign enter_clk  = (state_q == S_GAP_B) && (state_d == S_PULSE_CLK);
  assign finish_win = (state_q == S_WAIT_Q) && (state_d == S_RESULT);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE:      if (bus.in_valid) state_d = S_PULSE_A;
      S_PULSE_A:   begin state_d = S_GAP_A; timer_d = GAP_LAST; end
      S_GAP_A:     if (timer_q == 8'd0) state_d = S_PULSE_B; else timer_d = timer_q - 8'd1;
      S_PULSE_B:   begin state_d = S_GAP_B; timer_d = GAP_LAST; end
      S_GAP_B:     if (timer_q == 8'd0) state_d = S_PULSE_CLK; else timer_d = timer_q - 8'd1;
      S_PULSE_CLK: begin state_d = S_WAIT_Q; timer_d = WIN_LAST; end
      S_WAIT_Q:    if (timer_q == 8'd0) state_d = S_RESULT; else timer_d = timer_q - 8'd1;
      S_RESULT:    if (bus.out_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // det_q reflects a q transition from the previous cycle; it counts only while in WAIT_Q
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_WAIT_Q) && det_q && (cnt_q != 2'd3)) cnt_d = cnt_q + 2'd1;
    if (enter_clk) cnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      timer_q        <= 8'd0;
      cnt_q          <= 2'd0;
      a_q            <= 1'b0;
      b_q            <= 1'b0;
      sfq_a_q        <= 1'b0;
      sfq_b_q        <= 1'b0;
      sfq_clk_q      <= 1'b0;
      q_prev_q       <= bus.sfq_q;
      det_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      out_bit_q      <= 1'b0;
      out_mismatch_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      q_prev_q <= bus.sfq_q;
      det_q    <= bus.sfq_q ^ q_prev_q;
      if (transfer) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
      end
      // Pulses are launched on entry so each line changes level during its PULSE state
      if (transfer && bus.in_a) sfq_a_q <= ~sfq_a_q;
      if (enter_pb && b_q)      sfq_b_q <= ~sfq_b_q;
      if (enter_clk)            sfq_clk_q <= ~sfq_clk_q;
      if (det_q && (state_q != S_WAIT_Q)) err_q <= 1'b1;
      if (finish_win) begin
        out_valid_q    <= 1'b1;
        out_bit_q      <= (cnt_d != 2'd0);
        out_mismatch_q <= ((cnt_d != 2'd0) != ~(a_q ^ b_q)) | (cnt_d >= 2'd2);
      end else if ((state_q == S_RESULT) && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.sfq_a        = sfq_a_q;
  assign bus.sfq_b        = sfq_b_q;
  assign bus.sfq_clk      = sfq_clk_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_bit      = out_bit_q;
  assign bus.out_mismatch = out_mismatch_q;
  assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_rsfq_xnor_driver.sv
// Randomised and directed bench for rsfq_xnor_driver; expectations come from a per-transaction
// model of pulse timing, window membership of q toggles and the XNOR result rules.
module tb_rsfq_xnor_driver;
  localparam int G = 2;
  localparam int R = 8;
  localparam int L = 3 + 2 * G + R;
  localparam int CLK_N = 2 * G + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;
  logic exp_a = 1'b0, exp_b = 1'b0, exp_c = 1'b0, exp_err = 1'b0;

  rsfq_xnor_driver_if bus_if ();

  rsfq_xnor_driver #(.GAP_CYCLES(G), .RESP_WINDOW(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b (txn %0d)", tag, got, exp, txn_id);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_a = 1'b0; exp_b = 1'b0; exp_c = 1'b0; exp_err = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", bus_if.in_ready, 1'b1);
    check("rst_sfq_a", bus_if.sfq_a, 1'b0);
    check("rst_sfq_b", bus_if.sfq_b, 1'b0);
    check("rst_sfq_clk", bus_if.sfq_clk, 1'b0);
    check("rst_out_valid", bus_if.out_valid, 1'b0);
    check("rst_out_bit", bus_if.out_bit, 1'b0);
    check("rst_out_mismatch", bus_if.out_mismatch, 1'b0);
    check("rst_err", bus_if.err_spurious, 1'b0);
  endtask

  // qmask bit k: toggle sfq_q k cycles after the sfq_clk pulse; bit R lands just outside the window
  task automatic do_txn(input logic a, input logic b, input logic [R:0] qmask, input int hold);
    int   cnt;
    int   guard;
    int   idx;
    logic ob, om;
    txn_id++;
    guard = 0;
    while (!bus_if.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_idle", bus_if.in_ready, 1'b1);
    bus_if.in_valid = 1'b1;
    bus_if.in_a = a;
    bus_if.in_b = b;
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.in_a = 1'($urandom);
    bus_if.in_b = 1'($urandom);

    cnt = 0;
    for (int k = 0; k < R; k++) if (qmask[k]) cnt++;
    if (cnt > 3) cnt = 3;
    ob = (cnt != 0);
    om = (ob != (a ~^ b)) || (cnt >= 2);
    if (qmask[R]) exp_err = 1'b1;

    for (int n = 0; n < L; n++) begin
      check("busy_sfq_a", bus_if.sfq_a, exp_a ^ a);
      check("busy_sfq_b", bus_if.sfq_b, exp_b ^ (b && (n >= G + 1)));
      check("busy_sfq_clk", bus_if.sfq_clk, exp_c ^ (n >= CLK_N));
      check("busy_out_valid", bus_if.out_valid, 1'b0);
      idx = n - CLK_N;
      if (idx >= 0 && idx <= R) begin
        if (qmask[idx]) bus_if.sfq_q = ~bus_if.sfq_q;
      end
      tick();
    end
    exp_a = exp_a ^ a;
    exp_b = exp_b ^ b;
    exp_c = ~exp_c;

    check("latency_out_valid", bus_if.out_valid, 1'b1);
    check("out_bit", bus_if.out_bit, ob);
    check("out_mismatch", bus_if.out_mismatch, om);
    check("result_in_ready", bus_if.in_ready, 1'b0);
    bus_if.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_out_valid", bus_if.out_valid, 1'b1);
      check("hold_out_bit", bus_if.out_bit, ob);
      check("hold_out_mismatch", bus_if.out_mismatch, om);
      check("hold_in_ready", bus_if.in_ready, 1'b0);
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    check("done_out_valid", bus_if.out_valid, 1'b0);
    check("done_in_ready", bus_if.in_ready, 1'b1);
    check("done_err", bus_if.err_spurious, exp_err);
    check("done_sfq_a", bus_if.sfq_a, exp_a);
    check("done_sfq_b", bus_if.sfq_b, exp_b);
    check("done_sfq_clk", bus_if.sfq_clk, exp_c);
    $display("txn %0d a=%0b b=%0b qmask=%b hold=%0d -> bit=%0b mism=%0b err=%0b",
             txn_id, a, b, qmask, hold, bus_if.out_bit, bus_if.out_mismatch, bus_if.err_spurious);
  endtask

  initial begin
    logic [R:0] m;
    int         mode, i, j;
    bus_if.in_valid = 1'b0;
    bus_if.in_a = 1'b0;
    bus_if.in_b = 1'b0;
    bus_if.sfq_q = 1'b0;
    bus_if.out_ready = 1'b0;
    tick();
    do_reset();
    check_reset_state();

    do_txn(1'b0, 1'b0, 9'(1 << 3), 0);
    do_txn(1'b1, 1'b0, 9'd0, 0);
    do_txn(1'b1, 1'b1, 9'((1 << 1) | (1 << 5)), 0);
    do_txn(1'b0, 1'b1, 9'd0, 5);
    do_txn(1'b1, 1'b0, 9'(1 << (R - 1)), 1);
    do_txn(1'b0, 1'b1, 9'(1 << 0), 0);
    do_txn(1'b1, 1'b1, 9'((1 << R) - 1), 2);

    for (int t = 0; t < 40; t++) begin
      m = '0;
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        m[$urandom_range(0, R - 1)] = 1'b1;
      end else if (mode == 2) begin
        i = $urandom_range(0, R - 1);
        j = (i + 1 + $urandom_range(0, R - 2)) % R;
        m[i] = 1'b1;
        m[j] = 1'b1;
      end else if (mode == 3) begin
        for (int k = 0; k < R; k++) m[k] = 1'($urandom_range(0, 1));
      end
      do_txn(1'($urandom), 1'($urandom), m, $urandom_range(0, 3));
    end

    // Abort during GAP_B with a q edge coinciding with reset
    txn_id++;
    bus_if.in_valid = 1'b1;
    bus_if.in_a = 1'b1;
    bus_if.in_b = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    for (int n = 0; n < G + 2; n++) tick();
    bus_if.sfq_q = ~bus_if.sfq_q;
    do_reset();
    check_reset_state();
    for (int n = 0; n < L + 3; n++) begin
      tick();
      check("abort_sfq_clk", bus_if.sfq_clk, 1'b0);
      check("abort_out_valid", bus_if.out_valid, 1'b0);
      check("abort_err", bus_if.err_spurious, 1'b0);
    end
    $display("txn %0d aborted by reset in GAP_B", txn_id);
    do_txn(1'b0, 1'b0, 9'(1 << 2), 0);

    // q edge in the cycle after the window closes is spurious
    do_txn(1'b0, 1'b0, 9'(1 << R), 0);
    do_reset();
    check_reset_state();

    // q edge while idle is spurious and sticky until reset
    bus_if.sfq_q = ~bus_if.sfq_q;
    tick();
    tick();
    tick();
    exp_err = 1'b1;
    check("idle_spurious_err", bus_if.err_spurious, 1'b1);
    do_txn(1'b1, 1'b0, 9'd0, 0);
    check("sticky_err", bus_if.err_spurious, 1'b1);
    do_reset();
    check("err_cleared", bus_if.err_spurious, 1'b0);
    do_txn(1'b1, 1'b1, 9'(1 << 4), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
